// File: rtl/psram_responder.sv
// psram_responder: behavioural PSRAM slave that answers an SPI/QPI controller.
// Decodes the mode-switch and reset opcodes and serves quad read/write bursts
// from an internal word memory.
//
// Parameters:
//   WAIT_CYCLES - read turnaround edges between last address nibble and data
//   ADDR_BITS   - log2 of memory depth in 16-bit words
// Ports:
//   clk           - single clock, all state changes on its rising edge
//   rst           - synchronous active-high reset
//   mem_ce_n      - chip enable from the controller, active low
//   mem_sio[3:0]  - data lines; driven only while streaming read data
//   qpi_mode      - responder is in QPI mode
//   last_cmd[7:0] - opcode of the most recently completed command byte
//   cmd_err       - sticky unsupported-opcode flag
// Build option: define PSRAM_RESP_WRAP_EN to wrap bursts inside a 1024-byte
// page; otherwise bursts increment linearly across the whole memory.
module psram_responder #(
   parameter int unsigned WAIT_CYCLES = 6,
   parameter int unsigned ADDR_BITS   = 10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       mem_ce_n,
   inout  wire  [3:0] mem_sio,
   output logic       qpi_mode,
   output logic [7:0] last_cmd,
   output logic       cmd_err
);

   localparam int unsigned DEPTH = 1 << ADDR_BITS;
   localparam int unsigned CNT_W = $clog2(WAIT_CYCLES + 9);

   typedef enum logic [2:0] {
      IDLE, SPI_CMD, QPI_CMD, ADDR, WAIT, READ, WRITE, IGNORE
   } state_t;

   state_t               r_state;
   logic                 r_ce_prev;
   logic                 r_qpi;
   logic                 r_err;
   logic                 r_arm;      // last completed opcode was 0x66
   logic                 r_arm_ok;   // r_arm as seen when this transaction began
   logic                 r_wr;
   logic                 r_oe;
   logic [7:0]           r_last;
   logic [6:0]           r_sh;
   logic [CNT_W-1:0]     r_cnt;
   logic [19:0]          r_addr;
   logic [ADDR_BITS-1:0] r_idx;
   logic [1:0]           r_nib;
   logic [11:0]          r_wdata;
   logic [3:0]           r_sio_out;
   logic [15:0]          r_mem [DEPTH];

   logic [7:0]           w_spi_op;
   logic [7:0]           w_qpi_op;
   logic [7:0]           w_op;
   logic [23:0]          w_addr;
   logic [ADDR_BITS-1:0] w_idx_inc;
   logic [15:0]          w_rd_word;
   logic [3:0]           w_rd_nib;
   logic [15:0]          w_mem_wdata;
   logic                 w_mem_we;

   assign w_spi_op    = {r_sh, mem_sio[0]};
   assign w_qpi_op    = {r_sh[3:0], mem_sio};
   assign w_op        = (r_state == QPI_CMD) ? w_qpi_op : w_spi_op;
   assign w_addr      = {r_addr, mem_sio};
   assign w_rd_word   = r_mem[r_idx];
   assign w_mem_wdata = {r_wdata, mem_sio};
   assign w_mem_we    = !rst && !mem_ce_n && (r_state == WRITE) && (r_nib == 2'd3);

   // Burst word-index advance
`ifdef PSRAM_RESP_WRAP_EN
   localparam logic [ADDR_BITS-1:0] PAGE_MASK = ADDR_BITS'(511);
   assign w_idx_inc = (r_idx & ~PAGE_MASK) | ((r_idx + ADDR_BITS'(1)) & PAGE_MASK);
`else
   assign w_idx_inc = r_idx + ADDR_BITS'(1);
`endif

   // Nibble select, word MSB first
   always_comb begin
      w_rd_nib = w_rd_word[3:0];
      case (r_nib)
         2'd0:    w_rd_nib = w_rd_word[15:12];
         2'd1:    w_rd_nib = w_rd_word[11:8];
         2'd2:    w_rd_nib = w_rd_word[7:4];
         default: w_rd_nib = w_rd_word[3:0];
      endcase
   end

   assign mem_sio  = r_oe ? r_sio_out : 4'bz;
   assign qpi_mode = r_qpi;
   assign last_cmd = r_last;
   assign cmd_err  = r_err;

   // Memory write port; contents survive rst
   always_ff @(posedge clk) begin
      if (w_mem_we) r_mem[r_idx] <= w_mem_wdata;
   end

   // Protocol FSM
   always_ff @(posedge clk) begin
      r_ce_prev <= mem_ce_n;
      if (rst) begin
         r_state   <= IDLE;
         r_ce_prev <= 1'b0;   // no new transaction until CE# is seen high
         r_qpi     <= 1'b0;
         r_err     <= 1'b0;
         r_arm     <= 1'b0;
         r_arm_ok  <= 1'b0;
         r_wr      <= 1'b0;
         r_oe      <= 1'b0;
         r_last    <= 8'h00;
         r_sh      <= '0;
         r_cnt     <= '0;
         r_addr    <= '0;
         r_idx     <= '0;
         r_nib     <= '0;
         r_wdata   <= '0;
         r_sio_out <= '0;
      end else if (mem_ce_n) begin
         r_state <= IDLE;
         r_oe    <= 1'b0;
         r_nib   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (r_ce_prev) begin
                  r_arm_ok <= r_arm;
                  r_arm    <= 1'b0;
                  r_cnt    <= CNT_W'(1);
                  if (r_qpi) begin
                     r_sh    <= {3'b000, mem_sio};
                     r_state <= QPI_CMD;
                  end else begin
                     r_sh    <= {6'b000000, mem_sio[0]};
                     r_state <= SPI_CMD;
                  end
               end
            end
            SPI_CMD, QPI_CMD: begin
               if (r_state == QPI_CMD || r_cnt == CNT_W'(7)) begin
                  r_last  <= w_op;
                  r_state <= IGNORE;
                  r_cnt   <= '0;
                  r_nib   <= '0;
                  case (w_op)
                     8'h66: r_arm <= 1'b1;
                     8'h99: begin
                        if (r_arm_ok) begin
                           r_qpi <= 1'b0;
                           r_err <= 1'b0;
                        end
                     end
                     8'h35: begin
                        if (r_state == SPI_CMD) r_qpi <= 1'b1;
                        else                    r_err <= 1'b1;
                     end
                     8'hF5: begin
                        if (r_state == QPI_CMD) r_qpi <= 1'b0;
                        else                    r_err <= 1'b1;
                     end
                     8'hEB, 8'h38: begin
                        if (r_state == QPI_CMD) begin
                           r_wr    <= (w_op == 8'h38);
                           r_state <= ADDR;
                        end else begin
                           r_err <= 1'b1;
                        end
                     end
                     default: r_err <= 1'b1;
                  endcase
               end else begin
                  r_sh  <= w_spi_op[6:0];
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            ADDR: begin
               r_addr <= 20'(w_addr);
               if (r_cnt == CNT_W'(5)) begin
                  r_idx   <= ADDR_BITS'(w_addr >> 1);   // addr[0] is ignored
                  r_cnt   <= '0;
                  r_nib   <= '0;
                  r_state <= r_wr ? WRITE : ((WAIT_CYCLES == 0) ? READ : WAIT);
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            WAIT: begin
               if (r_cnt == CNT_W'(WAIT_CYCLES - 1)) r_state <= READ;
               else                                 r_cnt   <= r_cnt + CNT_W'(1);
            end
            READ: begin
               r_oe      <= 1'b1;
               r_sio_out <= w_rd_nib;
               r_nib     <= r_nib + 2'd1;
               if (r_nib == 2'd3) r_idx <= w_idx_inc;
            end
            WRITE: begin
               r_wdata <= w_mem_wdata[11:0];
               r_nib   <= r_nib + 2'd1;
               if (r_nib == 2'd3) r_idx <= w_idx_inc;
            end
            IGNORE: ;
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_psram_responder.sv
// tb_psram_responder: directed bench for psram_responder with a transaction-
// level model (mode flags, arm history, word memory) checked every cycle.
module tb_psram_responder;

   localparam int W = 6;

   logic       clk    = 1'b0;
   logic       rst    = 1'b1;
   logic       ce_n   = 1'b1;
   logic       tb_oe  = 1'b0;
   logic [3:0] tb_drv = 4'h0;
   wire  [3:0] sio;
   logic       qpi_mode;
   logic [7:0] last_cmd;
   logic       cmd_err;

   assign sio = tb_oe ? tb_drv : 4'bz;

   psram_responder #(.WAIT_CYCLES(W), .ADDR_BITS(10)) dut (
      .clk      (clk),
      .rst      (rst),
      .mem_ce_n (ce_n),
      .mem_sio  (sio),
      .qpi_mode (qpi_mode),
      .last_cmd (last_cmd),
      .cmd_err  (cmd_err)
   );

   always #5 clk = ~clk;

   // Model state
   logic        m_qpi = 1'b0;
   logic        m_err = 1'b0;
   logic [7:0]  m_last = 8'h00;
   logic        m_prev66 = 1'b0;   // previous transaction completed opcode 0x66
   logic        m_this66 = 1'b0;
   logic        m_sio_drv = 1'b0;
   logic [3:0]  m_sio_exp = 4'h0;
   logic [15:0] m_mem [1024];
   logic        chk_en = 1'b0;
   int          n_checks = 0;
   int          n_fail = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   // Per-cycle compare against the model
   always @(negedge clk) begin
      if (chk_en) begin
         chk("qpi_mode", 32'(qpi_mode), 32'(m_qpi));
         chk("last_cmd", 32'(last_cmd), 32'(m_last));
         chk("cmd_err", 32'(cmd_err), 32'(m_err));
         if (!tb_oe) begin
            if (m_sio_drv) chk("sio_data", 32'(sio), 32'(m_sio_exp));
            else chk("sio_released", 32'(!($isunknown(sio) || sio == 4'h0)), 32'd0);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Next word of a burst, computed on byte addresses
   function automatic int next_word(input int w);
      int b;
      b = 2 * w + 2;
`ifdef PSRAM_RESP_WRAP_EN
      b = ((2 * w) & ~1023) | (b & 1023);
`else
      b = b % 2048;
`endif
      return b / 2;
   endfunction

   task automatic tick(input logic ce, input logic oe, input logic [3:0] d);
      ce_n = ce; tb_oe = oe; tb_drv = d;
      @(posedge clk); #1;
   endtask

   task automatic model_reset();
      m_qpi = 1'b0; m_err = 1'b0; m_last = 8'h00;
      m_prev66 = 1'b0; m_this66 = 1'b0; m_sio_drv = 1'b0;
   endtask

   task automatic model_op(input logic [7:0] op);
      m_last = op;
      case (op)
         8'h66: m_this66 = 1'b1;
         8'h99: if (m_prev66) begin m_qpi = 1'b0; m_err = 1'b0; end
         8'h35: if (!m_qpi) m_qpi = 1'b1; else m_err = 1'b1;
         8'hF5: if (m_qpi) m_qpi = 1'b0; else m_err = 1'b1;
         8'hEB, 8'h38: if (!m_qpi) m_err = 1'b1;
         default: m_err = 1'b1;
      endcase
   endtask

   // One edge with CE# high: ends any transaction
   task automatic idle();
      tick(1'b1, 1'b0, 4'h0);
      m_sio_drv = 1'b0;
      m_prev66 = m_this66;
      m_this66 = 1'b0;
   endtask

   task automatic send_cmd(input logic [7:0] op);
      if (m_qpi) begin
         tick(1'b0, 1'b1, op[7:4]);
         tick(1'b0, 1'b1, op[3:0]);
      end else begin
         for (int i = 7; i >= 0; i--) tick(1'b0, 1'b1, {3'b000, op[i]});
      end
      model_op(op);
   endtask

   task automatic send_addr(input logic [23:0] a);
      for (int i = 5; i >= 0; i--) tick(1'b0, 1'b1, a[4*i +: 4]);
   endtask

   task automatic cmd_only(input logic [7:0] op);
      idle();
      send_cmd(op);
      repeat (2) tick(1'b0, 1'b0, 4'h0);
   endtask

   // nnib nibbles, first nibble taken from the most significant used position
   task automatic qpi_write(input logic [23:0] a, input logic [31:0] data, input int nnib);
      int idx;
      logic [15:0] word;
      logic [3:0] nib;
      idle();
      send_cmd(8'h38);
      send_addr(a);
      idx = int'(a[10:1]);
      word = 16'h0;
      for (int k = 0; k < nnib; k++) begin
         nib = data[4*(nnib-1-k) +: 4];
         tick(1'b0, 1'b1, nib);
         word = {word[11:0], nib};
         if (k % 4 == 3) begin
            m_mem[idx] = word;
            idx = next_word(idx);
         end
      end
   endtask

   task automatic qpi_read(input logic [23:0] a, input int nnib, output logic [31:0] got);
      int idx;
      idle();
      send_cmd(8'hEB);
      send_addr(a);
      idx = int'(a[10:1]);
      got = 32'h0;
      repeat (W) tick(1'b0, 1'b0, 4'h0);
      for (int n = 0; n < nnib; n++) begin
         tick(1'b0, 1'b0, 4'h0);
         m_sio_drv = 1'b1;
         m_sio_exp = 4'(m_mem[idx] >> (4 * (3 - n % 4)));
         if (n % 4 == 3) idx = next_word(idx);
         @(negedge clk);
         got = {got[27:0], sio};
      end
   endtask

   initial begin
      logic [31:0] got;
      logic [7:0]  pat;

      // Reset
      rst = 1'b1;
      tick(1'b1, 1'b0, 4'h0);
      model_reset();
      chk_en = 1'b1;
      repeat (2) tick(1'b1, 1'b0, 4'h0);
      rst = 1'b0;
      chk("reset_qpi", 32'(qpi_mode), 32'd0);
      chk("reset_last", 32'(last_cmd), 32'h00);
      chk("reset_err", 32'(cmd_err), 32'd0);

      // SPI 0x35 enters QPI
      cmd_only(8'h35);
      chk("spi35_qpi", 32'(qpi_mode), 32'd1);
      chk("spi35_last", 32'(last_cmd), 32'h35);
      chk("spi35_err", 32'(cmd_err), 32'd0);

      // Two-word write then burst read
      qpi_write(24'h000010, 32'hA5C31234, 8);
      qpi_read(24'h000010, 8, got);
      chk("rd_burst_0x10", got, 32'hA5C31234);
      qpi_read(24'h000011, 4, got);
      chk("rd_odd_addr", got, 32'h0000A5C3);

      // 0x99 without arming, then armed
      cmd_only(8'h99);
      chk("rst99_alone_qpi", 32'(qpi_mode), 32'd1);
      chk("rst99_alone_last", 32'(last_cmd), 32'h99);
      cmd_only(8'h66);
      cmd_only(8'h99);
      chk("rst6699_qpi", 32'(qpi_mode), 32'd0);

      // Aborted 0x99 disarms
      cmd_only(8'h35);
      cmd_only(8'h66);
      idle();
      tick(1'b0, 1'b1, 4'h9);
      cmd_only(8'h99);
      chk("abort99_qpi", 32'(qpi_mode), 32'd1);

      // Unsupported opcode, then normal read with sticky error
      cmd_only(8'h5A);
      chk("bad_op_err", 32'(cmd_err), 32'd1);
      chk("bad_op_last", 32'(last_cmd), 32'h5A);
      qpi_read(24'h000010, 4, got);
      chk("rd_after_err", got, 32'h0000A5C3);
      chk("err_sticky", 32'(cmd_err), 32'd1);

      // Device reset clears the error
      cmd_only(8'h66);
      cmd_only(8'h99);
      chk("devrst_err", 32'(cmd_err), 32'd0);
      cmd_only(8'h35);

      // Incomplete write word is discarded
      qpi_write(24'h000020, 32'h0000BEEF, 4);
      qpi_write(24'h000020, 32'h00000012, 2);
      qpi_read(24'h000020, 4, got);
      chk("partial_wr", got, 32'h0000BEEF);

      // Burst boundaries
      qpi_write(24'h0003FE, 32'h00001111, 4);
      qpi_write(24'h000400, 32'h00002222, 4);
      qpi_write(24'h000000, 32'h00003333, 4);
      qpi_write(24'h0007FE, 32'h00004444, 4);
      qpi_read(24'h0003FE, 8, got);
`ifdef PSRAM_RESP_WRAP_EN
      chk("burst_0x3FE", got, 32'h11113333);
`else
      chk("burst_0x3FE", got, 32'h11112222);
`endif
      qpi_read(24'h0007FE, 8, got);
`ifdef PSRAM_RESP_WRAP_EN
      chk("burst_0x7FE", got, 32'h44442222);
`else
      chk("burst_0x7FE", got, 32'h44443333);
`endif

      // Leave QPI, then 0xF5 in SPI is unsupported
      cmd_only(8'hF5);
      chk("f5_qpi", 32'(qpi_mode), 32'd0);
      cmd_only(8'hF5);
      chk("spi_f5_err", 32'(cmd_err), 32'd1);

      // rst in the middle of a write; remainder of the CE# low window ignored
      cmd_only(8'h35);
      idle();
      send_cmd(8'h38);
      send_addr(24'h000020);
      tick(1'b0, 1'b1, 4'h7);
      tick(1'b0, 1'b1, 4'h7);
      rst = 1'b1;
      tick(1'b0, 1'b1, 4'h7);
      model_reset();
      rst = 1'b0;
      pat = 8'h35;
      for (int i = 7; i >= 0; i--) tick(1'b0, 1'b1, {3'b000, pat[i]});
      chk("midrst_qpi", 32'(qpi_mode), 32'd0);
      chk("midrst_last", 32'(last_cmd), 32'h00);
      cmd_only(8'h35);
      qpi_read(24'h000020, 4, got);
      chk("midrst_mem", got, 32'h0000BEEF);
      idle();
      tick(1'b1, 1'b0, 4'h0);

      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/psram_responder.md
PSRAM_RESPONDER -- requirements
Module: psram_responder

Interface
REQ-001 SHALL provide parameter WAIT_CYCLES, default 6, meaning read turnaround cycles between the last address nibble and the first data nibble.
REQ-002 SHALL provide parameter ADDR_BITS, default 10, meaning log2 of the internal memory depth in 16-bit words.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port mem_ce_n, input, 1 bit: chip enable, active low, driven by the controller.
REQ-006 SHALL have port mem_sio, inout, 4 bits: SPI/QPI data lines, driven only during read data phase, else high-Z.
REQ-007 SHALL have port qpi_mode, output, 1 bit: 1 when the responder is in QPI mode.
REQ-008 SHALL have port last_cmd, output, 8 bits: opcode of the most recently completed command byte.
REQ-009 SHALL have port cmd_err, output, 1 bit: sticky flag for an unsupported opcode, cleared only by rst or device reset.

Function
REQ-010 SHALL sample mem_ce_n and mem_sio on every rising clk edge; a transaction SHALL start at the first edge sampling mem_ce_n=0 after mem_ce_n=1, and that edge's sio value is the first command bit/nibble.
REQ-011 SHALL use states IDLE, SPI_CMD, QPI_CMD, ADDR, WAIT, READ, WRITE, IGNORE.
REQ-012 SPI mode: SHALL shift 8 bits from mem_sio[0], MSB first; opcodes: 0x66 arms reset-enable, 0x99 performs device reset only if the immediately preceding transaction was 0x66, 0x35 sets qpi_mode=1.
REQ-013 QPI mode: SHALL take 2 nibbles as opcode, high nibble first; 0xEB = quad read, 0x38 = quad write, 0xF5 clears qpi_mode, 0x66/0x99 as in REQ-012.
REQ-014 For 0xEB/0x38 SHALL capture 6 address nibbles, MSB first, as a 24-bit byte address; word index = addr[ADDR_BITS:1], addr[0] ignored.
REQ-015 Read: after WAIT_CYCLES sampled wait edges, nibble n (n=0,1,2,...) SHALL be registered onto mem_sio on the rising edge WAIT_CYCLES+n+1 edges after the edge that sampled the last address nibble, word MSB nibble first.
REQ-016 Read burst: after every 4 nibbles the word index SHALL increment and the following word SHALL stream without gap until mem_ce_n=1.
REQ-017 Write: SHALL assemble data nibbles MSB first and commit each complete 16-bit word to memory on the edge sampling its 4th nibble, then increment the word index.
REQ-018 Edge sampling mem_ce_n=1 in any state SHALL return to IDLE, release mem_sio to high-Z at that edge, and discard an incomplete write word.
REQ-019 Unsupported opcode SHALL set cmd_err, update last_cmd and enter IGNORE until mem_ce_n=1; mem_sio is never driven in IGNORE.
REQ-020 Any opcode other than 0x66 SHALL disarm reset-enable; 0x66 followed by aborted 0x99 (incomplete byte) SHALL NOT reset.
REQ-021 Device reset (0x99) SHALL clear qpi_mode and cmd_err at the edge completing the opcode; memory contents are preserved.
REQ-022 Word index SHALL wrap modulo 2^ADDR_BITS at the end of memory.

Reset
REQ-023 rst SHALL force state IDLE, qpi_mode=0, last_cmd=0x00, cmd_err=0, reset-enable disarmed, mem_sio high-Z; memory contents undefined/untouched.
REQ-024 rst asserted mid-transaction SHALL abort it on that edge; the responder SHALL ignore the remainder until mem_ce_n=1 is sampled.

Configuration
REQ-025 With macro PSRAM_RESP_WRAP_EN defined, burst address increment SHALL wrap within the 1024-byte page (addr[9:1] increments, upper bits held); without it, increment is linear per REQ-022.

Verification
REQ-026 After rst, SPI 0x35 on sio[0] -> qpi_mode=1, last_cmd=0x35, cmd_err=0.
REQ-027 QPI write 0x38, addr 0x000010, data 0xA5C3 then 0x1234 -> read 0xEB addr 0x000010 returns nibbles A,5,C,3,1,2,3,4 starting WAIT_CYCLES+1 edges after last address nibble.
REQ-028 QPI 0x66 then 0x99 -> qpi_mode=0; QPI 0x99 alone -> qpi_mode stays 1, last_cmd=0x99.
REQ-029 QPI opcode 0x5A -> cmd_err=1, mem_sio stays high-Z; mem_ce_n pulse 1 then 0xEB read behaves normally, cmd_err remains 1.
REQ-030 Write 0x38 addr 0x000020 with mem_ce_n rising after 2 data nibbles -> word 0x10 unchanged on subsequent read.
REQ-031 With PSRAM_RESP_WRAP_EN, read burst from addr 0x0003FE spanning 2 words -> second word from addr 0x000000; without macro -> from word index 0x1FF+1 mod 2^ADDR_BITS (0x200 mod 1024 = 0x200).
